stack_pointer: RTL and testbench



---
 rtl/stack_pointer_pkg.sv | 7 +
 rtl/stack_pointer_step.sv | 14 +
 rtl/stack_pointer.sv | 43 ++++
 tb/tb_stack_pointer.sv | 105 ++++++++++
 4 files changed

// File: rtl/stack_pointer_pkg.sv
// stack_pointer_pkg: shared defaults and direction encodings for the stack pointer
package stack_pointer_pkg;
   localparam int SP_WIDTH = 16;
   localparam int SP_RESET_VALUE = 0;
   localparam logic DIR_PUSH = 1'b1;
   localparam logic DIR_POP = 1'b0;
endpackage

// File: rtl/stack_pointer_step.sv
// stack_pointer_step: combinational +/- STEP with carry (push) or borrow (pop) out
module stack_pointer_step import stack_pointer_pkg::*; #(
   parameter int WIDTH = SP_WIDTH,
   parameter int STEP = 1
) (
   input  logic [WIDTH-1:0] q,
   input  logic             d,
   output logic [WIDTH-1:0] nxt,
   output logic             cb
);
   localparam logic [WIDTH:0] S = (WIDTH+1)'(STEP);
   // extra top bit is the carry on push and the borrow on pop
   assign {cb, nxt} = (d == DIR_PUSH) ? {1'b0, q} + S : {1'b0, q} - S;
endmodule

// File: rtl/stack_pointer.sv
// stack_pointer: up/down pointer register; STACK_POINTER_BOUNDS_EN adds sticky ovf/udf with saturation
module stack_pointer import stack_pointer_pkg::*; #(
   parameter int WIDTH = SP_WIDTH,
   parameter int STEP = 1,
   parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(SP_RESET_VALUE)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             d,
   input  logic             en,
   output logic [WIDTH-1:0] q
`ifdef STACK_POINTER_BOUNDS_EN
   ,
   output logic             ovf,
   output logic             udf
`endif
);
   logic [WIDTH-1:0] nxt;
   logic             cb;
   stack_pointer_step #(.WIDTH(WIDTH), .STEP(STEP)) u_step (.q(q), .d(d), .nxt(nxt), .cb(cb));
`ifdef STACK_POINTER_BOUNDS_EN
   logic [WIDTH-1:0] sat;
   // out of range saturates toward the direction of travel: all ones on push, zero on pop
   assign sat = cb ? {WIDTH{d}} : nxt;
   always_ff @(posedge clk) begin
      if (rst) begin
         q   <= RESET_VALUE;
         ovf <= 1'b0;
         udf <= 1'b0;
      end else if (en) begin
         q   <= sat;
         ovf <= ovf | (cb & (d == DIR_PUSH));
         udf <= udf | (cb & (d == DIR_POP));
      end
   end
`else
   logic unused_cb;
   assign unused_cb = cb;
   always_ff @(posedge clk)
      if (rst) q <= RESET_VALUE;
      else if (en) q <= nxt;
`endif
endmodule

// File: tb/tb_stack_pointer.sv
// tb_stack_pointer: directed vectors for default and WIDTH=8/STEP=4/RESET_VALUE=0xF0 builds
module tb_stack_pointer;
   logic clk = 1'b0;
   logic rst, d, en, rst2, d2, en2;
   logic [15:0] q;
   logic [7:0]  q2;
   int vectors = 0;
   int miscompares = 0;
   always #5 clk = ~clk;
`ifdef STACK_POINTER_BOUNDS_EN
   logic ovf, udf, ovf2, udf2;
   stack_pointer dut (.clk(clk), .rst(rst), .d(d), .en(en), .q(q), .ovf(ovf), .udf(udf));
   stack_pointer #(.WIDTH(8), .STEP(4), .RESET_VALUE(8'hF0)) dut2 (.clk(clk), .rst(rst2), .d(d2), .en(en2), .q(q2), .ovf(ovf2), .udf(udf2));
`else
   stack_pointer dut (.clk(clk), .rst(rst), .d(d), .en(en), .q(q));
   stack_pointer #(.WIDTH(8), .STEP(4), .RESET_VALUE(8'hF0)) dut2 (.clk(clk), .rst(rst2), .d(d2), .en(en2), .q(q2));
`endif
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   initial begin
      rst = 1; en = 1; d = 1; rst2 = 1; en2 = 0; d2 = 0;
      tick();
      check("reset", q, 16'h0000);
      rst = 0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         check("count_up", q, 16'(i));
      end
      d = 0;
      for (int i = 9; i >= 7; i--) begin
         tick();
         check("count_down", q, 16'(i));
      end
      en = 0;
      for (int i = 0; i < 4; i++) begin
         d = ~d;
         tick();
         check("hold", q, 16'h0007);
      end
      en = 1; d = 1; rst = 1;
      tick();
      check("reset_mid", q, 16'h0000);
      rst = 0; d = 0;
      tick();
`ifdef STACK_POINTER_BOUNDS_EN
      check("pop_sat", q, 16'h0000);
      check("udf_set", {15'b0, udf}, 16'h0001);
      tick();
      check("udf_sticky", {15'b0, udf}, 16'h0001);
      d = 1;
      tick();
      check("push_after_udf", q, 16'h0001);
      check("udf_persist", {15'b0, udf}, 16'h0001);
      check("ovf_clear", {15'b0, ovf}, 16'h0000);
`else
      check("pop_wrap", q, 16'hFFFF);
      d = 1;
      tick();
      check("push_wrap", q, 16'h0000);
      d = 0;
      tick();
      check("pop_wrap2", q, 16'hFFFF);
`endif
      tick();
      check("p2_reset", {8'h00, q2}, 16'h00F0);
      rst2 = 0; en2 = 1; d2 = 1;
      tick();
      check("p2_push1", {8'h00, q2}, 16'h00F4);
      tick();
      check("p2_push2", {8'h00, q2}, 16'h00F8);
      tick();
      check("p2_push3", {8'h00, q2}, 16'h00FC);
      tick();
`ifdef STACK_POINTER_BOUNDS_EN
      check("p2_push_sat", {8'h00, q2}, 16'h00FF);
      check("p2_ovf", {15'b0, ovf2}, 16'h0001);
      d2 = 0;
      tick();
      check("p2_pop", {8'h00, q2}, 16'h00FB);
      check("p2_ovf_sticky", {15'b0, ovf2}, 16'h0001);
      rst2 = 1;
      tick();
      check("p2_ovf_rst", {15'b0, ovf2}, 16'h0000);
`else
      check("p2_push_wrap", {8'h00, q2}, 16'h0000);
      d2 = 0;
      tick();
      check("p2_pop_wrap", {8'h00, q2}, 16'h00FC);
      rst2 = 1;
      tick();
`endif
      check("p2_rst_again", {8'h00, q2}, 16'h00F0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
